// File: rtl/mul_div_unit_if.sv
// ----------------------------------------------------------------------------
// mul_div_unit_if
// Request/response bundle between the control path and the iterative
// multiply/divide unit.
//   start    : request strobe, honoured only while the unit is idle
//   op       : funct3 operation code (MUL..REMU)
//   a, b     : rs1 / rs2 operands
//   flush    : abort the in-flight operation
//   busy     : unit is not idle (stall the PC)
//   done     : one-cycle result-valid pulse
//   result   : registered result, held until the next done
//   div_zero : registered with result, set for a divide by zero
// master = requester (datapath), slave = the mul/div unit.
// ----------------------------------------------------------------------------
interface mul_div_unit_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            div_zero;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result, div_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result, div_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// ----------------------------------------------------------------------------
// mul_div_unit
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per clock, operating on magnitudes with sign correction
// applied in a single fix-up cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mul_div_unit_if.slave (start/op/a/b/flush in,
//           busy/done/result/div_zero out)
// Latency from the accepting edge: XLEN+2 edges normally, 2 edges for
// divide-by-zero and signed overflow.
// ----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    // State and datapath registers
    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [2:0]        op_q,     op_d;
    logic [XLEN-1:0]   a_q,      a_d;       // raw rs1, needed for div-by-zero / overflow results
    logic [XLEN-1:0]   opnd_q,   opnd_d;    // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q,    acc_d;     // {hi, lo}: product, or {remainder, quotient}
    logic              sa_q,     sa_d;      // rs1 taken as negative
    logic              sb_q,     sb_d;      // rs2 taken as negative
    logic              dz_q,     dz_d;      // fast path: divide by zero
    logic              ovf_q,    ovf_d;     // fast path: signed overflow
    logic [XLEN-1:0]   result_q, result_d;
    logic              divz_q,   divz_d;

    // Operand decode in IDLE
    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            is_div, start_dz, start_ovf;

    always_comb begin
        a_sgn     = ((bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                     (bus.op == OP_DIV)  || (bus.op == OP_REM)) && bus.a[XLEN-1];
        b_sgn     = ((bus.op == OP_MULH) || (bus.op == OP_DIV) ||
                     (bus.op == OP_REM)) && bus.b[XLEN-1];
        // Negating the most-negative value leaves the bit pattern unchanged,
        // which is exactly its unsigned magnitude.
        a_mag     = a_sgn ? -bus.a : bus.a;
        b_mag     = b_sgn ? -bus.b : bus.b;
        is_div    = bus.op[2];
        start_dz  = is_div && (bus.b == '0);
        start_ovf = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                    (bus.a == MOST_NEG) && (bus.b == ALL_ONES);
    end

    // One iteration of each algorithm
    logic [XLEN:0]   mul_sum;    // hi half + multiplicand, with carry
    logic [XLEN:0]   div_shift;  // remainder shifted left with next dividend bit
    logic [XLEN:0]   div_trial;  // trial subtraction; MSB set means negative
    logic [XLEN-1:0] div_rem_n;
    logic [XLEN-1:0] div_quo_n;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_trial = div_shift - {1'b0, opnd_q};
        if (!div_trial[XLEN]) begin
            div_rem_n = div_trial[XLEN-1:0];
            div_quo_n = {acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_rem_n = div_shift[XLEN-1:0];
            div_quo_n = {acc_q[XLEN-2:0], 1'b0};
        end
    end

    // Sign-corrected results for the fix-up cycle
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_fix  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            divz_q   <= divz_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        divz_d   = divz_q;

        case (state_q)
            S_IDLE: begin
                // flush alongside start suppresses the request
                if (bus.start && !bus.flush) begin
                    op_d  = bus.op;
                    a_d   = bus.a;
                    sa_d  = a_sgn;
                    sb_d  = b_sgn;
                    dz_d  = start_dz;
                    ovf_d = start_ovf;
                    cnt_d = '0;
                    if (is_div) begin
                        opnd_d = b_mag;
                        acc_d  = {{XLEN{1'b0}}, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{XLEN{1'b0}}, b_mag};
                    end
                    state_d = (start_dz || start_ovf) ? S_FIX : S_CALC;
                end
            end

            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[2]) begin
                        acc_d = {div_rem_n, div_quo_n};
                    end else if (acc_q[0]) begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[2*XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    divz_d = dz_q;
                    case (op_q)
                        OP_MUL:                        result_d = prod_fix[XLEN-1:0];
                        OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_fix[2*XLEN-1:XLEN];
                        OP_DIV, OP_DIVU: begin
                            if (dz_q)       result_d = ALL_ONES;
                            else if (ovf_q) result_d = a_q;
                            else            result_d = quo_fix;
                        end
                        OP_REM, OP_REMU: begin
                            if (dz_q)       result_d = a_q;
                            else if (ovf_q) result_d = '0;
                            else            result_d = rem_fix;
                        end
                        default:                       result_d = result_q;
                    endcase
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.div_zero = divz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mul_div_unit_if #(.XLEN(64)) bus64 ();
    mul_div_unit_if #(.XLEN(8))  bus8  ();

    mul_div_unit #(.XLEN(64), .CNT_W(7)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus64)
    );

    mul_div_unit #(.XLEN(8), .CNT_W(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    int n_vec    = 0;
    int n_miscmp = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Launch one op on the 64-bit unit, wait (bounded) for done and return
    // the result together with the edge count, accepting edge = 1.
    task automatic run64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output logic dz, output int edges);
        @(negedge clk);
        bus64.op    = op;
        bus64.a     = a;
        bus64.b     = b;
        bus64.start = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        bus64.start = 1'b0;
        bus64.a     = ~a;      // operands must have been latched
        bus64.b     = ~b;
        bus64.op    = ~op;
        while (bus64.done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
        end
        res = bus64.result;
        dz  = bus64.div_zero;
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int edges);
        @(negedge clk);
        bus8.op    = op;
        bus8.a     = a;
        bus8.b     = b;
        bus8.start = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = ~b;
        while (bus8.done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
        end
        res = bus8.result;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] res;
        logic [7:0]  res8;
        logic        dz;
        int          edges;
        int          pulses;

        rst_n       = 1'b0;
        bus64.start = 1'b0; bus64.op = 3'd0; bus64.a = '0; bus64.b = '0; bus64.flush = 1'b0;
        bus8.start  = 1'b0; bus8.op  = 3'd0; bus8.a  = '0; bus8.b  = '0; bus8.flush  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst busy",     64'(bus64.busy),     64'd0);
        chk("rst done",     64'(bus64.done),     64'd0);
        chk("rst result",   bus64.result,        64'd0);
        chk("rst div_zero", 64'(bus64.div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned divide, gives a nonzero result before the reset test
        run64(3'd5, 64'd100, 64'd7, res, dz, edges);
        chk("divu 100/7",       res, 64'd14);
        chk("divu edges",       64'(edges), 64'd66);
        run64(3'd7, 64'd100, 64'd7, res, dz, edges);
        chk("remu 100%7",       res, 64'd2);

        // Asynchronous reset in the middle of CALC (counter = 10)
        @(negedge clk);
        bus64.op = 3'd0; bus64.a = 64'd123; bus64.b = 64'd456; bus64.start = 1'b1;
        @(posedge clk);
        #1;
        bus64.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst busy",     64'(bus64.busy),     64'd0);
        chk("midrst done",     64'(bus64.done),     64'd0);
        chk("midrst result",   bus64.result,        64'd0);
        chk("midrst div_zero", 64'(bus64.div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run64(3'd0, 64'd7, 64'd6, res, dz, edges);
        chk("mul 7*6",          res, 64'd42);
        chk("mul edges",        64'(edges), 64'd66);

        run64(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, res, dz, edges);
        chk("mulh -1*-1",       res, 64'd0);
        run64(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, res, dz, edges);
        chk("mulhu ff*ff",      res, 64'hFFFF_FFFF_FFFF_FFFE);
        run64(3'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, res, dz, edges);
        chk("mulhsu -2*3",      res, 64'hFFFF_FFFF_FFFF_FFFF);

        run64(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res, dz, edges);
        chk("rem -7%2",         res, 64'hFFFF_FFFF_FFFF_FFFF);
        run64(3'd4, 64'd5, 64'd0, res, dz, edges);
        chk("div 5/0",          res, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("div 5/0 dz",       64'(dz), 64'd1);
        chk("div 5/0 edges",    64'(edges), 64'd2);
        run64(3'd6, 64'd5, 64'd0, res, dz, edges);
        chk("rem 5/0",          res, 64'd5);
        chk("rem 5/0 dz",       64'(dz), 64'd1);

        run64(3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, dz, edges);
        chk("div ovf",          res, 64'h8000_0000_0000_0000);
        chk("div ovf dz",       64'(dz), 64'd0);
        chk("div ovf edges",    64'(edges), 64'd2);
        run64(3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, dz, edges);
        chk("rem ovf",          res, 64'd0);

        run64(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res, dz, edges);
        chk("div -7/2",         res, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div -7/2 dz",      64'(dz), 64'd0);

        // flush at CALC counter = 5: no done, result keeps -3
        @(negedge clk);
        bus64.op = 3'd0; bus64.a = 64'd9; bus64.b = 64'd9; bus64.start = 1'b1;
        @(posedge clk);
        #1;
        bus64.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus64.flush = 1'b1;
        @(posedge clk);
        #1;
        bus64.flush = 1'b0;
        chk("flush busy",       64'(bus64.busy), 64'd0);
        pulses = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus64.done === 1'b1) pulses++;
        end
        chk("flush no done",    64'(pulses), 64'd0);
        chk("flush result",     bus64.result, 64'hFFFF_FFFF_FFFF_FFFD);

        // start held high: one done pulse, then re-acceptance in IDLE
        @(negedge clk);
        bus64.op = 3'd0; bus64.a = 64'd3; bus64.b = 64'd5; bus64.start = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 67; i++) begin
            @(posedge clk);
            #1;
            if (bus64.done === 1'b1) pulses++;
        end
        chk("hold pulses",      64'(pulses), 64'd1);
        chk("hold idle busy",   64'(bus64.busy), 64'd0);
        @(posedge clk);
        #1;
        bus64.start = 1'b0;
        chk("hold reaccept",    64'(bus64.busy), 64'd1);
        edges = 1;
        while (bus64.done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
        end
        chk("hold 2nd edges",   64'(edges), 64'd66);
        chk("hold 2nd result",  bus64.result, 64'd15);
        @(posedge clk);
        #1;

        // 8-bit instance
        run8(3'd0, 8'd7, 8'd6, res8, edges);
        chk("x8 mul 7*6",       64'(res8), 64'd42);
        chk("x8 mul edges",     64'(edges), 64'd10);
        run8(3'd3, 8'hFF, 8'hFF, res8, edges);
        chk("x8 mulhu ff*ff",   64'(res8), 64'hFE);
        run8(3'd4, 8'hF9, 8'd2, res8, edges);
        chk("x8 div -7/2",      64'(res8), 64'hFD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
